alu_op_scheduler: RTL and testbench

//  Shares one ALU datapath (ADD, SUB, MUL, SHR) between two requesters.

---
 rtl/alu_op_scheduler_pkg.sv | 20 ++
 rtl/alu_op_scheduler_alu_core.sv | 39 +++
 rtl/alu_op_scheduler.sv | 148 ++++++++++++++
 tb/tb_alu_op_scheduler.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_op_scheduler_pkg.sv
// Shared types for the ALU operation scheduler: op encodings, FSM states, default width.
package alu_pkg;

    localparam int ALU_WIDTH = 16;

    typedef enum logic [1:0] {
        ALU_ADD = 2'b00,
        ALU_SUB = 2'b01,
        ALU_MUL = 2'b10,
        ALU_SHR = 2'b11
    } alu_op_t;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        MUL,
        DONE
    } sched_state_t;

endpackage

// File: rtl/alu_op_scheduler_alu_core.sv
// Single-cycle ADD/SUB/SHR on latched operands; carry port exists only with ALU_SCHED_FLAGS_EN.
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic [1:0]         op,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [2*WIDTH-1:0] result
`ifdef ALU_SCHED_FLAGS_EN
    ,
    output logic               carry
`endif
);

    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;

    assign sum  = a + b;
    assign diff = a - b;

    always_comb begin
        result = '0;
        case (alu_op_t'(op))
            ALU_ADD: result = {{WIDTH{1'b0}}, sum};
            ALU_SUB: result = {{WIDTH{1'b0}}, diff};
            ALU_SHR: result = (32'(b) >= WIDTH) ? '0 : {{WIDTH{1'b0}}, a >> b};
            default: result = '0;
        endcase
    end

`ifdef ALU_SCHED_FLAGS_EN
    // Unsigned overflow shows up as a wrapped sum smaller than an addend.
    assign carry = (alu_op_t'(op) == ALU_ADD) ? (sum < a) :
                   (alu_op_t'(op) == ALU_SUB) ? (a < b)   : 1'b0;
`endif

endmodule

// File: rtl/alu_op_scheduler.sv
// Two-requester round-robin scheduler sharing one ALU; MUL is iterative shift-add.
// Optional ALU_SCHED_FLAGS_EN adds registered rsp_zero / rsp_carry outputs.
module alu_op_scheduler
    import alu_pkg::*;
#(
    parameter int WIDTH   = ALU_WIDTH,
    parameter int NUM_REQ = 2
) (
    input  logic                     CLK100MHZ,
    input  logic                     RST,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [2*NUM_REQ-1:0]     req_op,
    input  logic [NUM_REQ*WIDTH-1:0] req_a,
    input  logic [NUM_REQ*WIDTH-1:0] req_b,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic                     rsp_id,
    output logic [2*WIDTH-1:0]       rsp_result,
    output logic                     busy
`ifdef ALU_SCHED_FLAGS_EN
    ,
    output logic                     rsp_zero,
    output logic                     rsp_carry
`endif
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    sched_state_t       state, state_next;
    logic               last_grant;
    logic [NUM_REQ-1:0] grant;
    logic               sel;
    logic               accept;
    logic               last_iter;
    logic [1:0]         op_sel;
    logic [WIDTH-1:0]   a_sel, b_sel;
    logic [1:0]         op_q;
    logic [WIDTH-1:0]   a_q, b_q;
    logic [2*WIDTH-1:0] acc, mcand, acc_next;
    logic [2*WIDTH-1:0] core_result, done_value;
    logic [WIDTH-1:0]   mplier;
    logic [CNT_W-1:0]   count;
`ifdef ALU_SCHED_FLAGS_EN
    logic               core_carry;
`endif

    // On a tie the requester that did not win last time is served.
    always_comb begin
        grant = '0;
        case (req_valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last_grant ? 2'b01 : 2'b10;
            default: grant = '0;
        endcase
    end

    assign sel    = grant[1];
    assign op_sel = sel ? req_op[3:2] : req_op[1:0];
    assign a_sel  = sel ? req_a[2*WIDTH-1:WIDTH] : req_a[WIDTH-1:0];
    assign b_sel  = sel ? req_b[2*WIDTH-1:WIDTH] : req_b[WIDTH-1:0];
    assign accept = |(req_valid & req_ready);

    assign acc_next   = mplier[0] ? (acc + mcand) : acc;
    assign last_iter  = (state == MUL) && (count == CNT_W'(WIDTH - 1));
    assign done_value = (state == MUL) ? acc_next : core_result;

    always_comb begin
        state_next = state;
        req_ready  = '0;
        rsp_valid  = 1'b0;
        busy       = 1'b1;
        case (state)
            IDLE: begin
                busy      = 1'b0;
                req_ready = RST ? '0 : grant;
                if (accept)
                    state_next = (alu_op_t'(op_sel) == ALU_MUL) ? MUL : EXEC;
            end
            EXEC:    state_next = DONE;
            MUL:     if (last_iter) state_next = DONE;
            DONE: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK100MHZ or posedge RST) begin
        if (RST) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            rsp_id     <= 1'b0;
            count      <= '0;
            rsp_result <= '0;
`ifdef ALU_SCHED_FLAGS_EN
            rsp_zero   <= 1'b0;
            rsp_carry  <= 1'b0;
`endif
        end else begin
            state <= state_next;
            if (accept) begin
                last_grant <= sel;
                rsp_id     <= sel;
                count      <= '0;
            end else if (state == MUL) begin
                count <= count + CNT_W'(1);
            end
            if ((state == EXEC) || last_iter) begin
                rsp_result <= done_value;
`ifdef ALU_SCHED_FLAGS_EN
                rsp_zero   <= (done_value == '0);
                rsp_carry  <= (state == EXEC) && core_carry;
`endif
            end
        end
    end

    // Operand and multiplier datapath registers carry no reset.
    always_ff @(posedge CLK100MHZ) begin
        if (accept) begin
            op_q   <= op_sel;
            a_q    <= a_sel;
            b_q    <= b_sel;
            acc    <= '0;
            mcand  <= {{WIDTH{1'b0}}, a_sel};
            mplier <= b_sel;
        end else if (state == MUL) begin
            acc    <= acc_next;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
        end
    end

    alu_core #(.WIDTH(WIDTH)) u_core (
        .op     (op_q),
        .a      (a_q),
        .b      (b_q),
        .result (core_result)
`ifdef ALU_SCHED_FLAGS_EN
        ,
        .carry  (core_carry)
`endif
    );

endmodule

// File: tb/tb_alu_op_scheduler.sv
// Directed, table-driven bench for alu_op_scheduler (WIDTH=16); flag checks under ALU_SCHED_FLAGS_EN.
module tb_alu_op_scheduler;
    import alu_pkg::*;

    logic        clk;
    logic        rst;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [3:0]  req_op;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_id;
    logic [31:0] rsp_result;
    logic        busy;
`ifdef ALU_SCHED_FLAGS_EN
    logic        rsp_zero;
    logic        rsp_carry;
`endif

    int checks = 0;
    int errors = 0;

    alu_op_scheduler #(.WIDTH(16), .NUM_REQ(2)) dut (
        .CLK100MHZ  (clk),
        .RST        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_a      (req_a),
        .req_b      (req_b),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_result (rsp_result),
        .busy       (busy)
`ifdef ALU_SCHED_FLAGS_EN
        ,
        .rsp_zero   (rsp_zero),
        .rsp_carry  (rsp_carry)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        int          r;
        logic [1:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [31:0] exp;
        int          lat;
        logic        z;
        logic        c;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Called at a negedge after the accept edge; latency counts the accept edge as edge 1.
    task automatic wait_rsp(output int lat);
        lat = 1;
        while (!rsp_valid && lat < 40) begin
            check("busy_pending", busy, 1);
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic issue(input int r, input logic [1:0] op, input logic [15:0] a, input logic [15:0] b);
        @(negedge clk);
        req_valid    = 2'b00;
        req_valid[r] = 1'b1;
        req_op[r*2 +: 2]  = op;
        req_a[r*16 +: 16] = a;
        req_b[r*16 +: 16] = b;
        #1;
        check("req_ready_grant", req_ready, (r == 0) ? 2'b01 : 2'b10);
        @(posedge clk);
        @(negedge clk);
        req_valid = 2'b00;
        req_op    = 4'b1111;
        req_a     = 32'hDEAD_BEEF;
        req_b     = 32'hA5A5_5A5A;
    endtask

    initial begin
        int lat;
        int n;

        vecs[0]  = '{0, ALU_ADD, 16'h0001, 16'h0002, 32'h0000_0003, 2,  1'b0, 1'b0};
        vecs[1]  = '{0, ALU_SUB, 16'h0001, 16'h0002, 32'h0000_FFFF, 2,  1'b0, 1'b1};
        vecs[2]  = '{0, ALU_MUL, 16'hFFFF, 16'hFFFF, 32'hFFFE_0001, 17, 1'b0, 1'b0};
        vecs[3]  = '{0, ALU_SHR, 16'h0001, 16'h0002, 32'h0000_0000, 2,  1'b1, 1'b0};
        vecs[4]  = '{0, ALU_SHR, 16'h8000, 16'h0010, 32'h0000_0000, 2,  1'b1, 1'b0};
        vecs[5]  = '{1, ALU_SHR, 16'h8000, 16'h000F, 32'h0000_0001, 2,  1'b0, 1'b0};
        vecs[6]  = '{1, ALU_ADD, 16'hFFFF, 16'h0001, 32'h0000_0000, 2,  1'b1, 1'b1};
        vecs[7]  = '{1, ALU_MUL, 16'h0003, 16'h0005, 32'h0000_000F, 17, 1'b0, 1'b0};
        vecs[8]  = '{0, ALU_MUL, 16'h0000, 16'h1234, 32'h0000_0000, 17, 1'b1, 1'b0};
        vecs[9]  = '{0, ALU_SUB, 16'h0005, 16'h0003, 32'h0000_0002, 2,  1'b0, 1'b0};
        vecs[10] = '{1, ALU_ADD, 16'h1234, 16'h4321, 32'h0000_5555, 2,  1'b0, 1'b0};
        vecs[11] = '{1, ALU_SUB, 16'h0000, 16'hFFFF, 32'h0000_0001, 2,  1'b0, 1'b1};

        rst       = 1'b1;
        req_valid = 2'b11;
        req_op    = 4'b0000;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b1;
        #1;
        check("rst_req_ready", req_ready, 2'b00);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_rsp_result", rsp_result, 0);
        check("rst_rsp_id", rsp_id, 0);
        repeat (2) @(negedge clk);
        req_valid = 2'b00;
        rst       = 1'b0;

        // Single operations, including back-to-back grants of a sole requester.
        for (int i = 0; i < 12; i++) begin
            issue(vecs[i].r, vecs[i].op, vecs[i].a, vecs[i].b);
            check("busy_after_accept", busy, 1);
            wait_rsp(lat);
            check("latency", lat, vecs[i].lat);
            check("rsp_result", rsp_result, vecs[i].exp);
            check("rsp_id", rsp_id, vecs[i].r);
`ifdef ALU_SCHED_FLAGS_EN
            check("rsp_zero", rsp_zero, vecs[i].z);
            check("rsp_carry", rsp_carry, vecs[i].c);
`endif
            @(posedge clk);
            @(negedge clk);
            check("idle_rsp_valid", rsp_valid, 0);
            check("idle_busy", busy, 0);
        end

        // Consumer stall in DONE with both requesters pending.
        rsp_ready = 1'b0;
        issue(1, ALU_MUL, 16'h1234, 16'h0100);
        req_valid = 2'b11;
        req_op    = {ALU_ADD, ALU_ADD};
        req_a     = {16'h0007, 16'h0007};
        req_b     = {16'h0001, 16'h0001};
        wait_rsp(lat);
        check("stall_latency", lat, 17);
        for (int k = 0; k < 10; k++) begin
            check("stall_rsp_valid", rsp_valid, 1);
            check("stall_rsp_result", rsp_result, 32'h0012_3400);
            check("stall_rsp_id", rsp_id, 1);
            check("stall_req_ready", req_ready, 2'b00);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("stall_release_busy", busy, 0);
        check("stall_release_ready", req_ready, 2'b01);
        req_valid = 2'b00;
        @(negedge clk);
        check("drop_valid_busy", busy, 0);

        // Reset asserted mid-multiply.
        issue(1, ALU_MUL, 16'hFFFF, 16'hFFFF);
        req_valid = 2'b11;
        req_op    = {ALU_SUB, ALU_ADD};
        req_a     = {16'd100, 16'd10};
        req_b     = {16'd1, 16'd20};
        repeat (7) @(posedge clk);
        #2;
        check("pre_rst_busy", busy, 1);
        rst = 1'b1;
        #1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_rsp_valid", rsp_valid, 0);
        check("mid_rst_rsp_result", rsp_result, 0);
        check("mid_rst_rsp_id", rsp_id, 0);
        check("mid_rst_req_ready", req_ready, 2'b00);
        @(negedge clk);
        rst = 1'b0;
        #1;

        // Both requesters held valid: strict alternation starting with requester 0.
        for (int k = 0; k < 4; k++) begin
            n = 0;
            while (req_ready == 2'b00 && n < 20) begin
                @(negedge clk);
                n++;
            end
            check("rr_wait_cycles", n, 0);
            check("rr_grant", req_ready, (k % 2 == 0) ? 2'b01 : 2'b10);
            @(posedge clk);
            @(negedge clk);
            wait_rsp(lat);
            check("rr_latency", lat, 2);
            check("rr_rsp_id", rsp_id, k % 2);
            check("rr_rsp_result", rsp_result, (k % 2 == 0) ? 32'd30 : 32'd99);
            check("rr_done_req_ready", req_ready, 2'b00);
            @(posedge clk);
            @(negedge clk);
        end
        req_valid = 2'b00;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
